alarm_trigger: RTL

ALARM_TRIGGER -- requirements
Module: alarm_trigger

---
 rtl/alarm_trigger_pkg.sv | 18 +
 rtl/btn_debounce.sv | 54 +++++
 rtl/alarm_trigger.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alarm_trigger_pkg.sv
// Shared clock/alarm definitions: time field widths and the alarm FSM state codes.
package alarm_trigger_pkg;

    localparam int unsigned HH_W      = 5;
    localparam int unsigned MM_W      = 6;
    localparam int unsigned SS_W      = 6;
    localparam int unsigned STATE_W   = 2;
    localparam int unsigned SNZ_CNT_W = 2;
    localparam int unsigned SNZ_TMR_W = 10;

    typedef enum logic [STATE_W-1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StRinging = 2'd2,
        StSnooze  = 2'd3
    } alarm_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop synchronizer -> stable-high counter -> single press pulse per press.
module btn_debounce #(
    parameter int unsigned StableCycles = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CntW = $clog2(StableCycles + 1);

    logic            sync1_q, sync2_q;
    logic            fired_q, fired_d;
    logic            press_q, press_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            fired_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            fired_q <= fired_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt_q holds how many consecutive high samples were already seen; fired blocks re-trigger.
    always_comb begin
        cnt_d   = cnt_q;
        fired_d = fired_q;
        press_d = 1'b0;
        if (!sync2_q) begin
            cnt_d   = '0;
            fired_d = 1'b0;
        end else if (!fired_q) begin
            if (cnt_q == CntW'(StableCycles - 1)) begin
                press_d = 1'b1;
                fired_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/alarm_trigger.sv
// Alarm clock trigger: arms on enable, rings at alarm time, handles snooze/stop and hourly chime.
module alarm_trigger
    import alarm_trigger_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 25_000_000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned SNOOZE_MIN  = 5,
    parameter int unsigned MAX_SNOOZE  = 3,
    parameter int unsigned RING_S      = 60
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick_1hz,
    input  logic [HH_W-1:0]      cur_hh,
    input  logic [MM_W-1:0]      cur_mm,
    input  logic [SS_W-1:0]      cur_ss,
    input  logic [HH_W-1:0]      alm_hh,
    input  logic [MM_W-1:0]      alm_mm,
    input  logic                 alm_en,
    input  logic                 chime_en,
    input  logic                 snooze_btn,
    input  logic                 stop_btn,
    input  logic                 ring_busy,
    output logic                 ring_req,
    output logic                 chime_pulse,
    output logic [STATE_W-1:0]   state,
    output logic [SNZ_CNT_W-1:0] snooze_cnt,
    output logic                 alm_led
);

    localparam int unsigned DebRaw    = DEBOUNCE_MS * CLK_HZ / 1000;
    localparam int unsigned DebCycles = (DebRaw == 0) ? 1 : DebRaw;
    localparam int unsigned RingW     = $clog2(RING_S + 1);

    localparam logic [RingW-1:0]     RingMax = RingW'(RING_S);
    localparam logic [SNZ_TMR_W-1:0] SnzLoad = SNZ_TMR_W'(SNOOZE_MIN * 60);
    localparam logic [SNZ_CNT_W-1:0] SnzMax  = SNZ_CNT_W'(MAX_SNOOZE);

    logic snooze_pulse, stop_pulse;

    btn_debounce #(
        .StableCycles (DebCycles)
    ) u_snooze_deb (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (snooze_btn),
        .press_o (snooze_pulse)
    );

    btn_debounce #(
        .StableCycles (DebCycles)
    ) u_stop_deb (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (stop_btn),
        .press_o (stop_pulse)
    );

    alarm_state_e          state_q, state_d;
    logic [SNZ_CNT_W-1:0]  snz_cnt_q, snz_cnt_d;
    logic [RingW-1:0]      ring_tmr_q, ring_tmr_d;
    logic [SNZ_TMR_W-1:0]  snz_tmr_q, snz_tmr_d;
    logic                  ring_req_q, ring_req_d;
    logic                  chime_q, chime_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            snz_cnt_q  <= '0;
            ring_tmr_q <= '0;
            snz_tmr_q  <= '0;
            ring_req_q <= 1'b0;
            chime_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            snz_cnt_q  <= snz_cnt_d;
            ring_tmr_q <= ring_tmr_d;
            snz_tmr_q  <= snz_tmr_d;
            ring_req_q <= ring_req_d;
            chime_q    <= chime_d;
        end
    end

    logic             alarm_hit, snooze_ok;
    logic [RingW-1:0] ring_inc;

    always_comb begin
        alarm_hit  = tick_1hz && (cur_hh == alm_hh) && (cur_mm == alm_mm) && (cur_ss == '0);
        snooze_ok  = snz_cnt_q < SnzMax;
        ring_inc   = (ring_tmr_q >= RingMax) ? RingMax : ring_tmr_q + RingW'(1);
        state_d    = state_q;
        snz_cnt_d  = snz_cnt_q;
        ring_tmr_d = ring_tmr_q;
        snz_tmr_d  = snz_tmr_q;
        if (!alm_en) begin
            state_d    = StIdle;
            snz_cnt_d  = '0;
            ring_tmr_d = '0;
            snz_tmr_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StArmed;
                StArmed: begin
                    if (alarm_hit) begin
                        state_d    = StRinging;
                        ring_tmr_d = '0;
                        snz_cnt_d  = '0;
                    end
                end
                StRinging: begin
                    if (stop_pulse) begin
                        state_d = StArmed;
                    end else if (snooze_pulse && snooze_ok) begin
                        state_d   = StSnooze;
                        snz_cnt_d = snz_cnt_q + SNZ_CNT_W'(1);
                        snz_tmr_d = SnzLoad;
                    end else if (tick_1hz) begin
                        ring_tmr_d = ring_inc;
                        // Ring timeout behaves like a snooze press until snoozes run out.
                        if (ring_inc == RingMax) begin
                            if (snooze_ok) begin
                                state_d   = StSnooze;
                                snz_cnt_d = snz_cnt_q + SNZ_CNT_W'(1);
                                snz_tmr_d = SnzLoad;
                            end else begin
                                state_d = StArmed;
                            end
                        end
                    end
                end
                StSnooze: begin
                    if (stop_pulse) begin
                        state_d = StArmed;
                    end else if (tick_1hz) begin
                        if (snz_tmr_q <= SNZ_TMR_W'(1)) begin
                            state_d    = StRinging;
                            snz_tmr_d  = '0;
                            ring_tmr_d = '0;
                        end else begin
                            snz_tmr_d = snz_tmr_q - SNZ_TMR_W'(1);
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Chime is suppressed whenever the bell is (or is about to be) ringing.
    always_comb begin
        ring_req_d = (state_d == StRinging);
        chime_d    = tick_1hz && (cur_mm == '0) && (cur_ss == '0) && chime_en && !ring_busy &&
                     (state_q != StRinging) && (state_d != StRinging);
    end

    assign ring_req    = ring_req_q;
    assign chime_pulse = chime_q;
    assign state       = state_q;
    assign snooze_cnt  = snz_cnt_q;
    assign alm_led     = (state_q != StIdle);

endmodule
